// File: rtl/multicycle_control_if.sv
// Control-unit <-> datapath/memory bundle for the multi-cycle RV32I core.
// The control unit takes the master side; the datapath/memory side takes the slave side.
interface multicycle_control_if #(
    parameter int RETIRE_W = 32,
    parameter int ALU_OP_W = 2
);
    logic [6:0]          opcode;
    logic                mem_ready;
    logic                branch_taken;
    logic                mem_req;
    logic                mem_we;
    logic                addr_sel;
    logic                ir_write;
    logic                pc_write;
    logic [1:0]          pc_sel;
    logic                reg_write;
    logic                mem_to_reg;
    logic [1:0]          out_sel;
    logic                alu_src_1;
    logic                alu_src_2;
    logic [ALU_OP_W-1:0] alu_op;
    logic                instr_done;
    logic [RETIRE_W-1:0] retired;
    logic                trap;
    logic [1:0]          trap_cause;

    modport master (
        input  opcode, mem_ready, branch_taken,
        output mem_req, mem_we, addr_sel, ir_write, pc_write, pc_sel, reg_write,
               mem_to_reg, out_sel, alu_src_1, alu_src_2, alu_op, instr_done,
               retired, trap, trap_cause
    );

    modport slave (
        output opcode, mem_ready, branch_taken,
        input  mem_req, mem_we, addr_sel, ir_write, pc_write, pc_sel, reg_write,
               mem_to_reg, out_sel, alu_src_1, alu_src_2, alu_op, instr_done,
               retired, trap, trap_cause
    );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I sequencing FSM: FETCH/DECODE/EXECUTE/MEM/WB/TRAP with memory
// req/ready timeout, datapath select decoding and a retired-instruction counter.
module multicycle_control #(
    parameter int MEM_TIMEOUT = 15,
    parameter int RETIRE_W    = 32,
    parameter int ALU_OP_W    = 2
) (
    input logic                  clk,
    input logic                  rst_n,
    multicycle_control_if.master ctl
);
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_OP     = 7'h33;
    localparam logic [6:0] OP_OP_IMM = 7'h13;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;

    // CTL_ALU_* encodings shared with the ALU decoder in defines.v
    localparam logic [ALU_OP_W-1:0] ALU_ADD    = ALU_OP_W'(0);
    localparam logic [ALU_OP_W-1:0] ALU_OP     = ALU_OP_W'(1);
    localparam logic [ALU_OP_W-1:0] ALU_OP_IMM = ALU_OP_W'(2);
    localparam logic [ALU_OP_W-1:0] ALU_BRANCH = ALU_OP_W'(3);

    localparam int TMO_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, MEM, WB, TRAP} state_t;

    state_t              state, state_nxt;
    logic [TMO_W-1:0]    tmo_cnt;
    logic [RETIRE_W-1:0] retired;
    logic                trap;
    logic [1:0]          trap_cause, cause_nxt;
    logic                timed_out;
    logic                legal;
    logic                ex_src_1, ex_src_2;
    logic [ALU_OP_W-1:0] ex_op;

    assign timed_out = (MEM_TIMEOUT != 0) && !ctl.mem_ready &&
                       (tmo_cnt == TMO_W'(MEM_TIMEOUT - 1));

    assign ctl.retired    = retired;
    assign ctl.trap       = trap;
    assign ctl.trap_cause = trap_cause;

    always_comb begin
        legal    = 1'b1;
        ex_src_1 = 1'b0;
        ex_src_2 = 1'b0;
        ex_op    = ALU_ADD;
        case (ctl.opcode)
            OP_LOAD, OP_STORE: ex_src_2 = 1'b1;
            OP_OP:             ex_op = ALU_OP;
            OP_OP_IMM: begin
                ex_src_2 = 1'b1;
                ex_op    = ALU_OP_IMM;
            end
            OP_AUIPC: begin
                ex_src_1 = 1'b1;
                ex_src_2 = 1'b1;
            end
            OP_BRANCH:                 ex_op = ALU_BRANCH;
            OP_LUI, OP_JAL, OP_JALR:   ex_op = ALU_ADD;
            default:                   legal = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt      = state;
        cause_nxt      = 2'b00;
        ctl.mem_req    = 1'b0;
        ctl.mem_we     = 1'b0;
        ctl.addr_sel   = 1'b0;
        ctl.ir_write   = 1'b0;
        ctl.pc_write   = 1'b0;
        ctl.pc_sel     = 2'b00;
        ctl.reg_write  = 1'b0;
        ctl.mem_to_reg = 1'b0;
        ctl.out_sel    = 2'b00;
        ctl.alu_src_1  = 1'b0;
        ctl.alu_src_2  = 1'b0;
        ctl.alu_op     = ALU_ADD;
        ctl.instr_done = 1'b0;
        case (state)
            FETCH: begin
                ctl.mem_req = 1'b1;
                if (ctl.mem_ready) begin
                    ctl.ir_write = 1'b1;
                    state_nxt    = DECODE;
                end else if (timed_out) begin
                    state_nxt = TRAP;
                    cause_nxt = 2'b10;
                end
            end
            DECODE: begin
                if (legal) begin
                    state_nxt = EXECUTE;
                end else begin
                    state_nxt = TRAP;
                    cause_nxt = 2'b01;
                end
            end
            EXECUTE: begin
                ctl.alu_src_1 = ex_src_1;
                ctl.alu_src_2 = ex_src_2;
                ctl.alu_op    = ex_op;
                if (ctl.opcode == OP_LOAD || ctl.opcode == OP_STORE) begin
                    state_nxt = MEM;
                end else if (ctl.opcode == OP_BRANCH) begin
                    ctl.pc_write   = 1'b1;
                    ctl.pc_sel     = ctl.branch_taken ? 2'b10 : 2'b00;
                    ctl.instr_done = 1'b1;
                    state_nxt      = FETCH;
                end else begin
                    state_nxt = WB;
                end
            end
            MEM: begin
                // ALU selects stay as in EXECUTE so the memory address is stable
                ctl.mem_req   = 1'b1;
                ctl.addr_sel  = 1'b1;
                ctl.mem_we    = (ctl.opcode == OP_STORE);
                ctl.alu_src_1 = ex_src_1;
                ctl.alu_src_2 = ex_src_2;
                ctl.alu_op    = ex_op;
                if (ctl.mem_ready) begin
                    if (ctl.opcode == OP_STORE) begin
                        ctl.pc_write   = 1'b1;
                        ctl.instr_done = 1'b1;
                        state_nxt      = FETCH;
                    end else begin
                        state_nxt = WB;
                    end
                end else if (timed_out) begin
                    state_nxt = TRAP;
                    cause_nxt = 2'b11;
                end
            end
            WB: begin
                ctl.reg_write  = 1'b1;
                ctl.pc_write   = 1'b1;
                ctl.instr_done = 1'b1;
                state_nxt      = FETCH;
                ctl.alu_src_1  = ex_src_1;
                ctl.alu_src_2  = ex_src_2;
                ctl.alu_op     = ex_op;
                case (ctl.opcode)
                    OP_LOAD: ctl.mem_to_reg = 1'b1;
                    OP_LUI:  ctl.out_sel = 2'b01;
                    OP_JAL, OP_JALR: begin
                        ctl.out_sel   = 2'b10;
                        ctl.pc_sel    = 2'b01;
                        ctl.alu_src_1 = (ctl.opcode == OP_JAL);
                        ctl.alu_src_2 = 1'b1;
                        ctl.alu_op    = ALU_ADD;
                    end
                    default: ;
                endcase
            end
            TRAP:    state_nxt = TRAP;
            default: state_nxt = FETCH;
        endcase
        // Nothing may be written or requested while reset is held
        if (!rst_n) begin
            ctl.mem_req    = 1'b0;
            ctl.mem_we     = 1'b0;
            ctl.ir_write   = 1'b0;
            ctl.pc_write   = 1'b0;
            ctl.reg_write  = 1'b0;
            ctl.instr_done = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= FETCH;
            tmo_cnt    <= '0;
            retired    <= '0;
            trap       <= 1'b0;
            trap_cause <= 2'b00;
        end else begin
            state <= state_nxt;
            if (state_nxt != state && (state_nxt == FETCH || state_nxt == MEM))
                tmo_cnt <= '0;
            else if ((state == FETCH || state == MEM) && !ctl.mem_ready)
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            if (ctl.instr_done)
                retired <= retired + RETIRE_W'(1);
            if (state != TRAP && state_nxt == TRAP) begin
                trap       <= 1'b1;
                trap_cause <= cause_nxt;
            end
        end
    end
endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed cases plus random instruction stream checked
// against per-instruction expectations derived from cycle counts and output tables.
module tb_multicycle_control;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_OP     = 7'h33;
    localparam logic [6:0] OP_OP_IMM = 7'h13;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [1:0] ALU_ADD = 2'd0, ALU_OPR = 2'd1, ALU_OPI = 2'd2, ALU_BR = 2'd3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int bad = 0;
    int expRetired = 0;
    logic [6:0] legalOps [9] = '{OP_LOAD, OP_STORE, OP_OP, OP_OP_IMM, OP_LUI,
                                 OP_AUIPC, OP_BRANCH, OP_JAL, OP_JALR};

    multicycle_control_if #(.RETIRE_W(3), .ALU_OP_W(2)) bus ();

    multicycle_control #(.MEM_TIMEOUT(4), .RETIRE_W(3), .ALU_OP_W(2)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .ctl  (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // {alu_src_1, alu_src_2, alu_op} expected in EXECUTE for each opcode class
    function automatic logic [3:0] execAlu(input logic [6:0] op);
        case (op)
            OP_LOAD, OP_STORE: return {2'b01, ALU_ADD};
            OP_OP:             return {2'b00, ALU_OPR};
            OP_OP_IMM:         return {2'b01, ALU_OPI};
            OP_AUIPC:          return {2'b11, ALU_ADD};
            OP_BRANCH:         return {2'b00, ALU_BR};
            default:           return 4'b0000;
        endcase
    endfunction

    function automatic int baseCycles(input logic [6:0] op);
        if (op == OP_BRANCH) return 3;
        if (op == OP_LOAD)   return 5;
        return 4;
    endfunction

    task automatic driveCycle(input logic [6:0] op, input logic rdy);
        bus.opcode       = op;
        bus.mem_ready    = rdy;
        bus.branch_taken = 1'($urandom);
        @(negedge clk);
    endtask

    task automatic finishCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst_n            = 1'b0;
        bus.opcode       = OP_OP;
        bus.mem_ready    = 1'b1;
        bus.branch_taken = 1'b1;
        @(negedge clk);
        checkOutput("rst_write_enables",
                    {bus.ir_write, bus.pc_write, bus.reg_write, bus.mem_we, bus.instr_done}, 5'b0);
        checkOutput("rst_retired", bus.retired, 0);
        checkOutput("rst_trap", {bus.trap, bus.trap_cause}, 0);
        finishCycle();
        rst_n      = 1'b1;
        expRetired = 0;
    endtask

    // Runs one legal instruction with fw fetch wait cycles and mw memory wait cycles
    task automatic applyStimulus(input logic [6:0] op, input int fw, input int mw, input logic tk);
        bit isMem, hasWb;
        int nCyc, execC, memEnd;
        int nReq, nAddr1, nWe, nIr, nPc, nReg, nM2r;
        logic [3:0] exAlu, wbAlu;
        logic [1:0] finalPcSel, wbOutSel;
        isMem  = (op == OP_LOAD) || (op == OP_STORE);
        hasWb  = (op != OP_BRANCH) && (op != OP_STORE);
        nCyc   = baseCycles(op) + fw + (isMem ? mw : 0);
        execC  = fw + 3;
        memEnd = execC + 1 + mw;
        exAlu  = execAlu(op);
        wbAlu  = (op == OP_JAL) ? {2'b11, ALU_ADD} : (op == OP_JALR) ? {2'b01, ALU_ADD} : exAlu;
        wbOutSel   = (op == OP_LUI) ? 2'b01 : (op == OP_JAL || op == OP_JALR) ? 2'b10 : 2'b00;
        finalPcSel = (op == OP_BRANCH) ? (tk ? 2'b10 : 2'b00) :
                     (op == OP_JAL || op == OP_JALR) ? 2'b01 : 2'b00;
        nReq = 0; nAddr1 = 0; nWe = 0; nIr = 0; nPc = 0; nReg = 0; nM2r = 0;
        for (int c = 1; c <= nCyc; c++) begin
            bus.opcode = (c <= fw + 1) ? 7'($urandom) : op;
            if (c <= fw + 1)             bus.mem_ready = (c == fw + 1);
            else if (isMem && c > execC) bus.mem_ready = (c == memEnd);
            else                         bus.mem_ready = 1'($urandom);
            bus.branch_taken = (c == execC) ? tk : 1'($urandom);
            @(negedge clk);
            nReq   += int'(bus.mem_req);
            nAddr1 += int'(bus.mem_req && bus.addr_sel);
            nWe    += int'(bus.mem_we);
            nIr    += int'(bus.ir_write);
            nPc    += int'(bus.pc_write);
            nReg   += int'(bus.reg_write);
            nM2r   += int'(bus.mem_to_reg);
            checkOutput("instr_done", bus.instr_done, (c == nCyc));
            if (c == execC)
                checkOutput("exec_alu", {bus.alu_src_1, bus.alu_src_2, bus.alu_op}, exAlu);
            if (isMem && c == memEnd)
                checkOutput("mem_alu_hold", {bus.alu_src_1, bus.alu_src_2, bus.alu_op}, exAlu);
            if (c == nCyc) begin
                checkOutput("final_pc_sel", bus.pc_sel, finalPcSel);
                if (hasWb) begin
                    checkOutput("wb_reg_write", bus.reg_write, 1);
                    checkOutput("wb_out_sel", bus.out_sel, wbOutSel);
                    checkOutput("wb_alu", {bus.alu_src_1, bus.alu_src_2, bus.alu_op}, wbAlu);
                end
            end
            finishCycle();
        end
        expRetired = (expRetired + 1) % 8;
        checkOutput("mem_req_cycles", nReq, (fw + 1) + (isMem ? mw + 1 : 0));
        checkOutput("addr_sel_cycles", nAddr1, isMem ? mw + 1 : 0);
        checkOutput("mem_we_cycles", nWe, (op == OP_STORE) ? mw + 1 : 0);
        checkOutput("ir_write_cycles", nIr, 1);
        checkOutput("pc_write_cycles", nPc, 1);
        checkOutput("reg_write_cycles", nReg, hasWb ? 1 : 0);
        checkOutput("mem_to_reg_cycles", nM2r, (op == OP_LOAD) ? 1 : 0);
        checkOutput("retired", bus.retired, expRetired);
        checkOutput("no_trap", bus.trap, 0);
    endtask

    initial begin
        int cnt;
        $display("[TB] start");
        doReset();

        applyStimulus(OP_OP_IMM, 0, 0, 1'b0);
        applyStimulus(OP_LOAD, 0, 3, 1'b0);
        applyStimulus(OP_BRANCH, 0, 0, 1'b1);
        applyStimulus(OP_BRANCH, 0, 0, 1'b0);

        for (int i = 0; i < 30; i++)
            applyStimulus(legalOps[$urandom_range(0, 8)], $urandom_range(0, 3),
                          $urandom_range(0, 3), 1'($urandom));

        // Illegal opcode: trap after DECODE, then nothing moves
        driveCycle(OP_OP, 1'b1);
        finishCycle();
        driveCycle(7'h7F, 1'b1);
        checkOutput("illegal_decode_done", bus.instr_done, 0);
        finishCycle();
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            driveCycle(7'h7F, 1'($urandom));
            cnt += int'(bus.mem_req) + int'(bus.ir_write) + int'(bus.pc_write) +
                   int'(bus.reg_write) + int'(bus.mem_we) + int'(bus.instr_done);
            finishCycle();
        end
        checkOutput("illegal_trap", {bus.trap, bus.trap_cause}, 3'b101);
        checkOutput("illegal_quiet", cnt, 0);
        checkOutput("illegal_retired", bus.retired, expRetired);

        // STORE stuck in MEM: trap on the fourth waiting cycle
        doReset();
        cnt = 0;
        driveCycle(OP_STORE, 1'b1); cnt += int'(bus.pc_write); finishCycle();
        driveCycle(OP_STORE, 1'b0); cnt += int'(bus.pc_write); finishCycle();
        driveCycle(OP_STORE, 1'b0); cnt += int'(bus.pc_write); finishCycle();
        for (int i = 0; i < 4; i++) begin
            driveCycle(OP_STORE, 1'b0);
            checkOutput("mem_tmo_mem_we", bus.mem_we, 1);
            cnt += int'(bus.pc_write);
            finishCycle();
        end
        driveCycle(OP_STORE, 1'b1);
        cnt += int'(bus.pc_write);
        checkOutput("mem_tmo_trap", {bus.trap, bus.trap_cause}, 3'b111);
        checkOutput("mem_tmo_req", bus.mem_req, 0);
        checkOutput("mem_tmo_no_pc_write", cnt, 0);
        finishCycle();

        // Fetch never answered
        doReset();
        for (int i = 0; i < 3; i++) begin
            driveCycle(OP_OP, 1'b0);
            finishCycle();
        end
        driveCycle(OP_OP, 1'b0);
        checkOutput("fetch_tmo_pending", bus.trap, 0);
        finishCycle();
        driveCycle(OP_OP, 1'b1);
        checkOutput("fetch_tmo_trap", {bus.trap, bus.trap_cause}, 3'b110);
        checkOutput("fetch_tmo_ir_write", bus.ir_write, 0);
        finishCycle();

        // Reset in the middle of a STORE's MEM phase
        doReset();
        applyStimulus(OP_OP, 0, 0, 1'b0);
        driveCycle(OP_STORE, 1'b1); finishCycle();
        driveCycle(OP_STORE, 1'b0); finishCycle();
        driveCycle(OP_STORE, 1'b0); finishCycle();
        driveCycle(OP_STORE, 1'b0);
        checkOutput("abort_mem_we_before", bus.mem_we, 1);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_mem_we_in_reset", bus.mem_we, 0);
        checkOutput("abort_retired", bus.retired, 0);
        finishCycle();
        rst_n = 1'b1;
        expRetired = 0;
        driveCycle(OP_STORE, 1'b0);
        checkOutput("abort_fetch", {bus.mem_req, bus.addr_sel, bus.mem_we}, 3'b100);
        checkOutput("abort_retired_after", bus.retired, 0);
        finishCycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
